// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out receiver: rebuilds WIDTH-bit words from an MSB-first
// bit stream framed by Start/Shift_En, with a valid/ack output slot and sticky overrun.
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             Clock,
    input  logic             Clear,
    input  logic             SI,
    input  logic             Shift_En,
    input  logic             Start,
    input  logic             Data_Ack,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Data_Valid,
    output logic             Busy,
    output logic             Overrun
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               valid_q, valid_d;
    logic               ovr_q, ovr_d;
    logic [WIDTH-1:0]   word;

    assign word = {sh_q[WIDTH-2:0], SI};

    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;

        if (valid_q && Data_Ack) begin
            valid_d = 1'b0;
        end

        if (Shift_En) begin
            if (Start) begin
                // A Start in SHIFT silently abandons the partial word.
                sh_d    = {{(WIDTH-1){1'b0}}, SI};
                cnt_d   = CNT_W'(1);
                state_d = SHIFT;
            end else if (state_q == SHIFT) begin
                sh_d = word;
                if (cnt_q == LAST_BIT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    if (!valid_q || Data_Ack) begin
                        data_d  = word;
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign Data_Out   = data_q;
    assign Data_Valid = valid_q;
    assign Busy       = (state_q == SHIFT);
    assign Overrun    = ovr_q;

endmodule
